// File: rtl/data_mem_responder.sv
// data_mem_responder
// Memory-side responder for the datapath load/store port. Accepts one request
// at a time and answers after WAIT_STATES extra cycles. Requests hit a word RAM
// (byte addresses 0 .. DEPTH_WORDS*4-1), an LED register at MMIO_BASE or a
// free-running cycle counter at MMIO_BASE+4. Misaligned or unmapped addresses
// answer with err=1 and have no side effects.
//
// Ports:
//   clk      clock, all state changes on its rising edge
//   reset    synchronous active-high reset
//   req      request strobe, sampled only in IDLE
//   we       1 = store, 0 = load (sampled with req)
//   addr     byte address (sampled with req)
//   wdata    store data (sampled with req)
//   rdata    load data, valid while ready=1, otherwise 0
//   ready    one-cycle response pulse
//   err      transaction error, valid while ready=1, otherwise 0
//   led_out  current LED register value
//
// state  | meaning
// IDLE   | waiting for req; accepts and latches the request
// WAIT   | counting down wait states for the latched request
// RESP   | ready pulse; a store commits on the edge leaving this state
module data_mem_responder #(
    parameter int          DEPTH_WORDS = 64,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic [7:0]  led_out
);

    localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [31:0] CNT_ADDR  = MMIO_BASE + 32'd4;
    localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  state_q,     state_d;
    logic [3:0]  wait_cnt_q,  wait_cnt_d;
    logic [31:0] addr_q,      addr_d;
    logic        we_q,        we_d;
    logic [31:0] wdata_q,     wdata_d;
    logic [31:0] snap_q,      snap_d;
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [7:0]  led_q,       led_d;
    logic [31:0] rdata_q,     rdata_d;
    logic        err_q,       err_d;
    logic        ready_q,     ready_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic             in_idle;
    logic [31:0]      src_addr;
    logic             src_we;
    logic [31:0]      src_snap;
    logic [IDX_W-1:0] ram_idx;
    logic             misaligned, hit_ram, hit_led, hit_cnt;
    logic             dec_err;
    logic [31:0]      dec_rdata;
    logic             go_resp;
    logic             ram_we;

    // The response is registered on the edge entering RESP. With zero wait
    // states that edge is the acceptance edge itself, so decode looks at the
    // live request in IDLE and at the latched request otherwise.
    always_comb begin
        in_idle  = (state_q == S_IDLE);
        src_addr = in_idle ? addr : addr_q;
        src_we   = in_idle ? we : we_q;
        src_snap = in_idle ? cycle_cnt_q : snap_q;
        ram_idx  = src_addr[IDX_W+1:2];

        misaligned = (src_addr[1:0] != 2'b00);
        hit_ram    = !misaligned && (src_addr < RAM_BYTES);
        hit_led    = !misaligned && (src_addr == MMIO_BASE);
        hit_cnt    = !misaligned && (src_addr == CNT_ADDR);

        dec_err   = !(hit_ram || hit_led || hit_cnt);
        dec_rdata = 32'd0;
        if (hit_ram) begin
            dec_rdata = mem_q[ram_idx];
        end else if (hit_led) begin
            dec_rdata = {24'd0, led_q};
        end else if (hit_cnt) begin
            dec_rdata = src_snap;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        snap_d      = snap_q;
        cycle_cnt_d = cycle_cnt_q + 32'd1;
        led_d       = led_q;
        go_resp     = 1'b0;
        ram_we      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d     = addr;
                    we_d       = we;
                    wdata_d    = wdata;
                    snap_d     = cycle_cnt_q;
                    wait_cnt_d = WAIT_LOAD;
                    if (WAIT_STATES == 0) begin
                        state_d = S_RESP;
                        go_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    go_resp = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                if (we_q && hit_ram) begin
                    ram_we = !reset;
                end
                if (we_q && hit_led) begin
                    led_d = wdata_q[7:0];
                end
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = go_resp;
        err_d   = go_resp && dec_err;
        rdata_d = (go_resp && !src_we) ? dec_rdata : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= 4'd0;
            addr_q      <= 32'd0;
            we_q        <= 1'b0;
            wdata_q     <= 32'd0;
            snap_q      <= 32'd0;
            cycle_cnt_q <= 32'd0;
            led_q       <= 8'd0;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            snap_q      <= snap_d;
            cycle_cnt_q <= cycle_cnt_d;
            led_q       <= led_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            ready_q     <= ready_d;
        end
    end

    // RAM contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem_q[ram_idx] <= wdata_q;
        end
    end

    assign rdata   = rdata_q;
    assign err     = err_q;
    assign ready   = ready_q;
    assign led_out = led_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, we;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        ready, err;
    logic [7:0]  led_out;

    logic        req_sw;
    logic        tie_we = 1'b0;
    logic [31:0] tie_addr = 32'd0;
    logic [31:0] tie_wdata = 32'd0;
    logic [31:0] rd_s0, rd_s1, rd_s3;
    logic        rdy_s0, rdy_s1, rdy_s3;
    logic        err_s0, err_s1, err_s3;
    logic [7:0]  led_s0, led_s1, led_s3;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.WAIT_STATES(1)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .err(err), .led_out(led_out));

    data_mem_responder #(.WAIT_STATES(0)) dut_s0 (
        .clk(clk), .reset(reset), .req(req_sw), .we(tie_we), .addr(tie_addr), .wdata(tie_wdata),
        .rdata(rd_s0), .ready(rdy_s0), .err(err_s0), .led_out(led_s0));

    data_mem_responder #(.WAIT_STATES(1)) dut_s1 (
        .clk(clk), .reset(reset), .req(req_sw), .we(tie_we), .addr(tie_addr), .wdata(tie_wdata),
        .rdata(rd_s1), .ready(rdy_s1), .err(err_s1), .led_out(led_s1));

    data_mem_responder #(.WAIT_STATES(3)) dut_s3 (
        .clk(clk), .reset(reset), .req(req_sw), .we(tie_we), .addr(tie_addr), .wdata(tie_wdata),
        .rdata(rd_s3), .ready(rdy_s3), .err(err_s3), .led_out(led_s3));

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [7:0]  exp_led;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Starts at a negedge in IDLE; returns at the negedge one cycle after RESP.
    task automatic do_txn(input logic t_we, input logic [31:0] t_addr, input logic [31:0] t_wdata,
                          output logic got, output int lat, output logic [31:0] rd,
                          output logic er, output logic rdy_after, output logic [7:0] led_after);
        req = 1'b1; we = t_we; addr = t_addr; wdata = t_wdata;
        got = 1'b0; lat = 0; rd = 32'd0; er = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            req = 1'b0; we = 1'b0; addr = 32'hFFFF_FFF0; wdata = 32'hA5A5_5A5A;
            if (ready) begin
                got = 1'b1; rd = rdata; er = err;
            end
        end
        @(negedge clk);
        rdy_after = ready;
        led_after = led_out;
    endtask

    task automatic reset_pulse(input int cycles);
        reset = 1'b1;
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
    endtask

    logic        got, er, rdy_after;
    int          lat;
    logic [31:0] rd;
    logic [7:0]  led_after;
    logic        seen;

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 32'h0000_0000, 32'h0,         32'hDEAD_BEEF, 1'b0, 8'h00};
        vecs[2]  = '{1'b1, 32'h0000_0004, 32'hCAFE_F00D, 32'h0000_0000, 1'b0, 8'h00};
        vecs[3]  = '{1'b1, 32'h0000_0006, 32'h0000_1234, 32'h0000_0000, 1'b1, 8'h00};
        vecs[4]  = '{1'b0, 32'h0000_0004, 32'h0,         32'hCAFE_F00D, 1'b0, 8'h00};
        vecs[5]  = '{1'b0, 32'h0000_0100, 32'h0,         32'h0000_0000, 1'b1, 8'h00};
        vecs[6]  = '{1'b0, 32'hFFFF_0008, 32'h0,         32'h0000_0000, 1'b1, 8'h00};
        vecs[7]  = '{1'b1, 32'h0000_00FC, 32'h1122_3344, 32'h0000_0000, 1'b0, 8'h00};
        vecs[8]  = '{1'b0, 32'h0000_00FC, 32'h0,         32'h1122_3344, 1'b0, 8'h00};
        vecs[9]  = '{1'b1, 32'h0000_0100, 32'h5555_5555, 32'h0000_0000, 1'b1, 8'h00};
        vecs[10] = '{1'b0, 32'h0000_0000, 32'h0,         32'hDEAD_BEEF, 1'b0, 8'h00};
        vecs[11] = '{1'b1, 32'hFFFF_0000, 32'h0000_01A5, 32'h0000_0000, 1'b0, 8'hA5};
        vecs[12] = '{1'b0, 32'hFFFF_0000, 32'h0,         32'h0000_00A5, 1'b0, 8'hA5};
        vecs[13] = '{1'b1, 32'hFFFF_0001, 32'h0000_00FF, 32'h0000_0000, 1'b1, 8'hA5};
        vecs[14] = '{1'b1, 32'hFFFF_0004, 32'h0000_0077, 32'h0000_0000, 1'b0, 8'hA5};
        vecs[15] = '{1'b0, 32'hFFFF_0002, 32'h0,         32'h0000_0000, 1'b1, 8'hA5};
        vecs[16] = '{1'b0, 32'h0000_0002, 32'h0,         32'h0000_0000, 1'b1, 8'hA5};

        reset = 1'b1; req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0; req_sw = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_ready", {31'd0, ready}, 32'd0);
        check("reset_err",   {31'd0, err},   32'd0);
        check("reset_rdata", rdata,          32'd0);
        check("reset_led",   {24'd0, led_out}, 32'd0);

        // Back-to-back sweep with req held high on three wait-state settings.
        begin
            int          last [3];
            int          cnt  [3];
            logic        prev [3];
            logic        cur  [3];
            int          per  [3];
            per[0] = 2; per[1] = 3; per[2] = 5;
            for (int k = 0; k < 3; k++) begin last[k] = -1; cnt[k] = 0; prev[k] = 1'b0; end
            req_sw = 1'b1;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                cur[0] = rdy_s0; cur[1] = rdy_s1; cur[2] = rdy_s3;
                for (int k = 0; k < 3; k++) begin
                    if (cur[k]) begin
                        check($sformatf("sweep_width_ws%0d", per[k] - 2), {31'd0, prev[k]}, 32'd0);
                        if (last[k] >= 0)
                            check($sformatf("sweep_period_ws%0d", per[k] - 2), c - last[k], per[k]);
                        last[k] = c;
                        cnt[k]++;
                    end
                    prev[k] = cur[k];
                end
            end
            req_sw = 1'b0;
            for (int k = 0; k < 3; k++)
                check($sformatf("sweep_pulses_ws%0d", per[k] - 2), {31'd0, (cnt[k] >= 6)}, 32'd1);
            repeat (6) @(negedge clk);
        end

        for (int i = 0; i < NV; i++) begin
            do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, got, lat, rd, er, rdy_after, led_after);
            check($sformatf("v%0d_got_ready", i), {31'd0, got}, 32'd1);
            check($sformatf("v%0d_latency", i), lat, 2);
            check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("v%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
            check($sformatf("v%0d_ready_drop", i), {31'd0, rdy_after}, 32'd0);
            check($sformatf("v%0d_led", i), {24'd0, led_after}, {24'd0, vecs[i].exp_led});
        end

        // Idle outputs are zero between transactions.
        check("idle_rdata", rdata, 32'd0);
        check("idle_err", {31'd0, err}, 32'd0);

        // Cycle counter snapshot: acceptance on the 10th cycle after reset release.
        reset_pulse(2);
        repeat (9) @(negedge clk);
        do_txn(1'b0, 32'hFFFF_0004, 32'd0, got, lat, rd, er, rdy_after, led_after);
        check("cnt_got_ready", {31'd0, got}, 32'd1);
        check("cnt_value", rd, 32'd9);
        check("cnt_err", {31'd0, er}, 32'd0);
        check("cnt_led_after_reset", {24'd0, led_after}, 32'd0);

        // Set LED, then abandon a second LED store with reset during WAIT.
        do_txn(1'b1, 32'hFFFF_0000, 32'h0000_005A, got, lat, rd, er, rdy_after, led_after);
        check("led5a_value", {24'd0, led_after}, 32'h5A);
        req = 1'b1; we = 1'b1; addr = 32'hFFFF_0000; wdata = 32'h0000_00C3;
        @(negedge clk);
        req = 1'b0; we = 1'b0;
        reset = 1'b1;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ready) seen = 1'b1;
        end
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ready) seen = 1'b1;
        end
        check("abort_no_ready", {31'd0, seen}, 32'd0);
        check("abort_led", {24'd0, led_out}, 32'd0);
        check("abort_rdata", rdata, 32'd0);

        // Counter restarts from 0 after that reset.
        reset_pulse(1);
        repeat (9) @(negedge clk);
        do_txn(1'b0, 32'hFFFF_0004, 32'd0, got, lat, rd, er, rdy_after, led_after);
        check("cnt2_value", rd, 32'd9);
        check("cnt2_led", {24'd0, led_after}, 32'd0);

        // Request presented together with reset is not accepted.
        req = 1'b1; we = 1'b1; addr = 32'hFFFF_0000; wdata = 32'h0000_0033;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; req = 1'b0; we = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (ready) seen = 1'b1;
        end
        check("reset_req_no_ready", {31'd0, seen}, 32'd0);
        check("reset_req_led", {24'd0, led_out}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
